// File: rtl/icw_ocw_write_sequencer.sv
// icw_ocw_write_sequencer
// Write-side front end of the interrupt controller. Synchronises the CPU
// write strobe and decodes each completed write into a one-cycle ICW1..ICW4
// or OCW1..OCW3 pulse. The written byte is presented on DOut.
// Optional feature: define PROTOCOL_ERR_EN to add the sticky protErr output,
// which flags writes that were ignored.
module icw_ocw_write_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csn,
  input  logic       wrn,
  input  logic       A0,
  input  logic [7:0] DBus,
  output logic       ICW1flag,
  output logic       ICW2flag,
  output logic       ICW3flag,
  output logic       ICW4flag,
  output logic       OCW1flag,
  output logic       OCW2flag,
  output logic       OCW3flag,
  output logic [7:0] DOut,
`ifdef PROTOCOL_ERR_EN
  output logic       protErr,
`endif
  output logic       initDone
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  localparam logic [6:0] F_ICW1 = 7'b0000001;
  localparam logic [6:0] F_ICW2 = 7'b0000010;
  localparam logic [6:0] F_ICW3 = 7'b0000100;
  localparam logic [6:0] F_ICW4 = 7'b0001000;
  localparam logic [6:0] F_OCW1 = 7'b0010000;
  localparam logic [6:0] F_OCW2 = 7'b0100000;
  localparam logic [6:0] F_OCW3 = 7'b1000000;

  logic [SYNC_STAGES-1:0]      csn_sync_r;
  logic [SYNC_STAGES-1:0]      wrn_sync_r;
  logic [SYNC_STAGES-1:0]      a0_sync_r;
  logic [SYNC_STAGES-1:0][7:0] dbus_sync_r;
  logic [SYNC_STAGES-1:0]      fill_r;

  logic       csn_s, wrn_s, a0_s, real_s, active_s, commit_s;
  logic [7:0] dbus_s;

  logic       armed_r, active_prev_r, hold_a0_r;
  logic [7:0] hold_data_r;

  logic [2:0] state_r, nxt_state;
  logic       sngl_r, nxt_sngl, ic4_r, nxt_ic4;
  logic [6:0] flags_r, nxt_flags;
  logic [7:0] dout_r, nxt_dout;
  logic       init_done_r;

  assign csn_s  = csn_sync_r[SYNC_STAGES-1];
  assign wrn_s  = wrn_sync_r[SYNC_STAGES-1];
  assign a0_s   = a0_sync_r[SYNC_STAGES-1];
  assign dbus_s = dbus_sync_r[SYNC_STAGES-1];
  // fill_r marks when the pipeline holds real samples rather than reset values
  assign real_s = fill_r[SYNC_STAGES-1];

  // A write only counts once a genuine high wrn has been seen since reset,
  // so a strobe already low when reset releases can never commit.
  assign active_s = armed_r & ~csn_s & ~wrn_s;
  assign commit_s = wrn_s & active_prev_r;

  // Synchroniser chains for the strobes, with A0/DBus pipelined alongside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csn_sync_r  <= {SYNC_STAGES{1'b1}};
      wrn_sync_r  <= {SYNC_STAGES{1'b1}};
      a0_sync_r   <= {SYNC_STAGES{1'b0}};
      dbus_sync_r <= {(SYNC_STAGES*8){1'b0}};
      fill_r      <= {SYNC_STAGES{1'b0}};
    end else begin
      csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], csn};
      wrn_sync_r  <= {wrn_sync_r[SYNC_STAGES-2:0], wrn};
      a0_sync_r   <= {a0_sync_r[SYNC_STAGES-2:0], A0};
      dbus_sync_r <= {dbus_sync_r[SYNC_STAGES-2:0], DBus};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Arm on idle strobe, track previous activity and hold address/data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_r       <= 1'b0;
      active_prev_r <= 1'b0;
      hold_a0_r     <= 1'b0;
      hold_data_r   <= 8'h00;
    end else begin
      armed_r       <= armed_r | (real_s & wrn_s);
      active_prev_r <= active_s;
      if (active_s) begin
        hold_a0_r   <= a0_s;
        hold_data_r <= dbus_s;
      end
    end
  end

  // Decode a committed write against the initialisation sequence
  always_comb begin
    nxt_state = state_r;
    nxt_sngl  = sngl_r;
    nxt_ic4   = ic4_r;
    nxt_dout  = dout_r;
    nxt_flags = 7'd0;
    if (commit_s) begin
      if (!hold_a0_r && hold_data_r[4]) begin
        nxt_flags = F_ICW1;
        nxt_sngl  = hold_data_r[1];
        nxt_ic4   = hold_data_r[0];
        nxt_state = WAIT_ICW2;
        nxt_dout  = hold_data_r;
      end else if (hold_a0_r) begin
        case (state_r)
          IDLE: begin
            nxt_state = IDLE;
          end
          WAIT_ICW2: begin
            nxt_flags = F_ICW2;
            nxt_dout  = hold_data_r;
            if (!sngl_r) begin
              nxt_state = WAIT_ICW3;
            end else if (ic4_r) begin
              nxt_state = WAIT_ICW4;
            end else begin
              nxt_state = READY;
            end
          end
          WAIT_ICW3: begin
            nxt_flags = F_ICW3;
            nxt_dout  = hold_data_r;
            if (ic4_r) begin
              nxt_state = WAIT_ICW4;
            end else begin
              nxt_state = READY;
            end
          end
          WAIT_ICW4: begin
            nxt_flags = F_ICW4;
            nxt_dout  = hold_data_r;
            nxt_state = READY;
          end
          READY: begin
            nxt_flags = F_OCW1;
            nxt_dout  = hold_data_r;
          end
          default: begin
            nxt_state = IDLE;
          end
        endcase
      end else if (state_r == READY) begin
        nxt_dout = hold_data_r;
        if (hold_data_r[3]) begin
          nxt_flags = F_OCW3;
        end else begin
          nxt_flags = F_OCW2;
        end
      end else begin
        nxt_state = state_r;
      end
    end else begin
      nxt_state = state_r;
    end
  end

  // Register state, sequence options and the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sngl_r      <= 1'b0;
      ic4_r       <= 1'b0;
      flags_r     <= 7'd0;
      dout_r      <= 8'h00;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= nxt_state;
      sngl_r      <= nxt_sngl;
      ic4_r       <= nxt_ic4;
      flags_r     <= nxt_flags;
      dout_r      <= nxt_dout;
      init_done_r <= (nxt_state == READY);
    end
  end

`ifdef PROTOCOL_ERR_EN
  logic ignored_s;
  logic prot_err_r;
  assign ignored_s = commit_s & (nxt_flags == 7'd0);

  // Sticky error on ignored writes, cleared by a fresh ICW1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prot_err_r <= 1'b0;
    end else if (nxt_flags == F_ICW1) begin
      prot_err_r <= 1'b0;
    end else if (ignored_s) begin
      prot_err_r <= 1'b1;
    end
  end

  assign protErr = prot_err_r;
`endif

  assign ICW1flag = flags_r[0];
  assign ICW2flag = flags_r[1];
  assign ICW3flag = flags_r[2];
  assign ICW4flag = flags_r[3];
  assign OCW1flag = flags_r[4];
  assign OCW2flag = flags_r[5];
  assign OCW3flag = flags_r[6];
  assign DOut     = dout_r;
  assign initDone = init_done_r;

endmodule

// File: tb/tb_icw_ocw_write_sequencer.sv
// Self-checking bench for icw_ocw_write_sequencer: directed sequences plus
// randomized writes, compared against a queue-based model of the ICW order.
module tb_icw_ocw_write_sequencer;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, csn, wrn, A0;
  logic [7:0] DBus;
  logic ICW1flag, ICW2flag, ICW3flag, ICW4flag, OCW1flag, OCW2flag, OCW3flag;
  logic [7:0] DOut;
  logic initDone;
`ifdef PROTOCOL_ERR_EN
  logic protErr;
`endif

  icw_ocw_write_sequencer #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .csn(csn), .wrn(wrn), .A0(A0), .DBus(DBus),
    .ICW1flag(ICW1flag), .ICW2flag(ICW2flag), .ICW3flag(ICW3flag),
    .ICW4flag(ICW4flag), .OCW1flag(OCW1flag), .OCW2flag(OCW2flag),
    .OCW3flag(OCW3flag), .DOut(DOut),
`ifdef PROTOCOL_ERR_EN
    .protErr(protErr),
`endif
    .initDone(initDone)
  );

  logic [6:0] flags_vec;
  assign flags_vec = {OCW3flag, OCW2flag, OCW1flag, ICW4flag, ICW3flag, ICW2flag, ICW1flag};

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the ICWs still owed after ICW1, kept as a queue
  int         m_q[$];
  bit         m_ready;
  logic [7:0] m_dout;
  bit         m_err;

  function automatic void model_reset();
    m_q.delete();
    m_ready = 1'b0;
    m_dout  = 8'h00;
    m_err   = 1'b0;
  endfunction

  // Returns the expected flag vector (bit0 ICW1 .. bit6 OCW3)
  function automatic logic [6:0] model_write(input bit a0, input logic [7:0] d);
    int n;
    if (!a0 && d[4]) begin
      m_q.delete();
      m_q.push_back(2);
      if (!d[1]) m_q.push_back(3);
      if (d[0])  m_q.push_back(4);
      m_ready = 1'b0;
      m_dout  = d;
      m_err   = 1'b0;
      return 7'b0000001;
    end
    if (a0) begin
      if (m_ready) begin
        m_dout = d;
        return 7'b0010000;
      end
      if (m_q.size() > 0) begin
        n = m_q.pop_front();
        if (m_q.size() == 0) m_ready = 1'b1;
        m_dout = d;
        return 7'(1) << (n - 1);
      end
      m_err = 1'b1;
      return 7'd0;
    end
    if (m_ready) begin
      m_dout = d;
      return d[3] ? 7'b1000000 : 7'b0100000;
    end
    m_err = 1'b1;
    return 7'd0;
  endfunction

  // Watch the window after a wrn rise: the flag must appear exactly S+1 cycles later
  task automatic observe(input logic [6:0] exp, input string tag);
    logic [6:0] at;
    logic [6:0] other;
    at = 7'd0;
    other = 7'd0;
    for (int k = 1; k <= S + 4; k++) begin
      @(negedge clk);
      if (k == S + 1) at = flags_vec;
      else other |= flags_vec;
      if (k == 1) csn = 1'b1;
    end
    check_value({tag, "_flag"}, {25'd0, at}, {25'd0, exp});
    check_value({tag, "_quiet"}, {25'd0, other}, 32'd0);
    check_value({tag, "_dout"}, {24'd0, DOut}, {24'd0, m_dout});
    check_value({tag, "_initdone"}, {31'd0, initDone}, {31'd0, m_ready});
`ifdef PROTOCOL_ERR_EN
    check_value({tag, "_proterr"}, {31'd0, protErr}, {31'd0, m_err});
`endif
  endtask

  task automatic do_write(input bit a0, input logic [7:0] d, input int low_cycles, input string tag);
    logic [6:0] exp;
    exp = model_write(a0, d);
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; A0 = a0; DBus = d;
    repeat (low_cycles) @(negedge clk);
    wrn = 1'b1;
    observe(exp, tag);
  endtask

  initial begin
    bit         ra0;
    logic [7:0] rd;
    reset = 1'b1; csn = 1'b1; wrn = 1'b1; A0 = 1'b0; DBus = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_value("rst_flags", {25'd0, flags_vec}, 32'd0);
    check_value("rst_dout", {24'd0, DOut}, 32'd0);
    check_value("rst_initdone", {31'd0, initDone}, 32'd0);
    reset = 1'b0;
    repeat (S + 3) @(negedge clk);

    // Ignored writes before any ICW1
    do_write(1'b1, 8'hAA, 2, "pre_a0hi");
    do_write(1'b0, 8'h0A, 2, "pre_a0lo");

    // Single, with ICW4
    do_write(1'b0, 8'h13, 2, "icw1_13");
    do_write(1'b1, 8'h48, 2, "icw2_48");
    do_write(1'b1, 8'h01, 2, "icw4_01");

    // Cascade, with ICW3 and ICW4
    do_write(1'b0, 8'h11, 2, "icw1_11");
    do_write(1'b1, 8'h20, 2, "icw2_20");
    do_write(1'b1, 8'h04, 2, "icw3_04");
    do_write(1'b1, 8'h01, 3, "icw4_01b");

    // Operation commands
    do_write(1'b1, 8'hFB, 2, "ocw1_fb");
    do_write(1'b0, 8'h20, 2, "ocw2_20");
    do_write(1'b0, 8'h0B, 2, "ocw3_0b");

    // Restart from WAIT_ICW3
    do_write(1'b0, 8'h11, 2, "re_icw1_11");
    do_write(1'b1, 8'h20, 2, "re_icw2_20");
    do_write(1'b0, 8'h13, 2, "re_icw1_13");
    do_write(1'b1, 8'h48, 2, "re_icw2_48");
    do_write(1'b1, 8'h01, 2, "re_icw4_01");

    // Long strobe yields a single pulse
    do_write(1'b1, 8'h5A, 10, "long_wrn");

    // csn released before wrn: no commit
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; A0 = 1'b1; DBus = 8'h55;
    repeat (3) @(negedge clk);
    csn = 1'b1;
    repeat (3) @(negedge clk);
    wrn = 1'b1;
    observe(7'd0, "csn_first");

    // Reset while wrn low: no commit after release
    @(negedge clk);
    csn = 1'b0; wrn = 1'b0; A0 = 1'b0; DBus = 8'h13;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (S + 4) @(negedge clk);
    wrn = 1'b1;
    observe(7'd0, "rst_midwrite");

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      ra0 = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        ra0 = 1'b0;
        rd[4] = 1'b1;
      end
      do_write(ra0, rd, $urandom_range(1, 4), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
